// File: rtl/aes_ctr_feeder.sv
// AES-CTR counter-block feeder.
// Issues consecutive counter blocks into a fixed-latency round pipeline and
// tracks which pipeline outputs carry keystream, flagging the last block of
// each run and pulsing done when that block emerges.
module aes_ctr_feeder #(
   parameter int block_size = 128,
   parameter int LATENCY    = 7,
   parameter int CTR_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  iv_load,
   input  logic [block_size-1:0] iv_in,
   input  logic                  start,
   input  logic [15:0]           num_blocks,
   input  logic                  hold,
   output logic [block_size-1:0] ctr_block,
   output logic                  issue_valid,
   output logic                  ks_valid,
   output logic                  ks_last,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                  state_reg, state_next;
   logic [block_size-1:0]   ctr_reg, ctr_next, ctr_inc;
   logic [15:0]             rem_reg, rem_next;
   logic                    zero_done_reg, zero_done_next;
   logic [LATENCY-1:0]      valid_sr_reg;
   logic [LATENCY-1:0]      last_sr_reg;
   logic                    last_issue;

   // Counter increment: only the low CTR_WIDTH bits count, the nonce part is untouched
   always_comb begin
      ctr_inc                  = ctr_reg;
      ctr_inc[CTR_WIDTH-1:0]   = ctr_reg[CTR_WIDTH-1:0] + {{(CTR_WIDTH-1){1'b0}}, 1'b1};
   end

   // State, counter, remaining count and zero-length-run done flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         ctr_reg       <= '0;
         rem_reg       <= '0;
         zero_done_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         ctr_reg       <= ctr_next;
         rem_reg       <= rem_next;
         zero_done_reg <= zero_done_next;
      end
   end

   // Next-state and issue control; start takes priority over iv_load in IDLE
   always_comb begin
      state_next     = state_reg;
      ctr_next       = ctr_reg;
      rem_next       = rem_reg;
      zero_done_next = 1'b0;
      issue_valid    = 1'b0;
      done           = zero_done_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (num_blocks != 16'd0) begin
                  state_next = ISSUE;
                  rem_next   = num_blocks;
               end else begin
                  zero_done_next = 1'b1;
               end
            end else if (iv_load) begin
               ctr_next = iv_in;
            end
         end
         ISSUE: begin
            if (!hold) begin
               issue_valid = 1'b1;
               ctr_next    = ctr_inc;
               rem_next    = rem_reg - 16'd1;
               if (rem_reg == 16'd1) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (ks_valid && ks_last) begin
               state_next = IDLE;
               done       = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign last_issue = issue_valid && (rem_reg == 16'd1);

   // First stage of the valid/last pipelines tracks the block entering the rounds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_sr_reg[0] <= 1'b0;
         last_sr_reg[0]  <= 1'b0;
      end else begin
         valid_sr_reg[0] <= issue_valid;
         last_sr_reg[0]  <= last_issue;
      end
   end

   genvar gi;
   generate
      for (gi = 1; gi < LATENCY; gi = gi + 1) begin : g_stage
         // Remaining stages shadow the round pipeline one edge per stage
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               valid_sr_reg[gi] <= 1'b0;
               last_sr_reg[gi]  <= 1'b0;
            end else begin
               valid_sr_reg[gi] <= valid_sr_reg[gi-1];
               last_sr_reg[gi]  <= last_sr_reg[gi-1];
            end
         end
      end
   endgenerate

   assign ctr_block = ctr_reg;
   assign ks_valid  = valid_sr_reg[LATENCY-1];
   assign ks_last   = last_sr_reg[LATENCY-1];
   assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_aes_ctr_feeder.sv
// Testbench for aes_ctr_feeder: directed scenarios with literal expectations
// plus a randomized phase, all outputs checked every cycle against a
// run-level behavioural model (issue events queued, keystream due LAT later).
module tb_aes_ctr_feeder;
   localparam int BS  = 128;
   localparam int LAT = 7;
   localparam int CW  = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          iv_load;
   logic [BS-1:0] iv_in;
   logic          start;
   logic [15:0]   num_blocks;
   logic          hold;
   logic [BS-1:0] ctr_block;
   logic          issue_valid, ks_valid, ks_last, busy, done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes_ctr_feeder #(.block_size(BS), .LATENCY(LAT), .CTR_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .iv_load(iv_load), .iv_in(iv_in),
      .start(start), .num_blocks(num_blocks), .hold(hold),
      .ctr_block(ctr_block), .issue_valid(issue_valid), .ks_valid(ks_valid),
      .ks_last(ks_last), .busy(busy), .done(done)
   );

   task automatic chk(input string name, input logic [BS-1:0] act, input logic [BS-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int cyc;
      bit last;
   } ev_t;

   ev_t           q[$];
   int            m_phase = 0;   // 0 idle, 1 issuing, 2 waiting for keystream
   int            m_rem = 0;
   logic [BS-1:0] m_ctr = '0;
   bit            m_done_pend = 0;
   int            cyc = 0;
   bit            e_iv, e_ks, e_last, e_done, e_busy;
   ev_t           ev;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_phase = 0; m_rem = 0; m_ctr = '0; m_done_pend = 0; q.delete();
      end
      e_iv   = (m_phase == 1) && !hold;
      e_ks   = (q.size() > 0) && (q[0].cyc + LAT == cyc);
      e_last = e_ks && q[0].last;
      e_done = m_done_pend || e_last;
      e_busy = (m_phase != 0);
      chk("m_ctr_block", ctr_block, m_ctr);
      chk("m_issue_valid", issue_valid, e_iv);
      chk("m_ks_valid", ks_valid, e_ks);
      chk("m_ks_last", ks_last, e_last);
      chk("m_busy", busy, e_busy);
      chk("m_done", done, e_done);
      if (rst_n) begin
         if (e_ks) void'(q.pop_front());
         m_done_pend = 0;
         if (m_phase == 0) begin
            if (start) begin
               if (num_blocks == 0) m_done_pend = 1;
               else begin m_phase = 1; m_rem = num_blocks; end
            end else if (iv_load) begin
               m_ctr = iv_in;
            end
         end else if (m_phase == 1) begin
            if (!hold) begin
               ev.cyc = cyc; ev.last = (m_rem == 1);
               q.push_back(ev);
               m_ctr[CW-1:0] = m_ctr[CW-1:0] + 1;
               m_rem--;
               if (m_rem == 0) m_phase = 2;
            end
         end else if (e_last) begin
            m_phase = 0;
         end
      end
      cyc++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_issue(input string name);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (issue_valid === 1'b1) return;
      end
      chk({name, "_timeout"}, 0, 1);
   endtask

   task automatic wait_ks(input string name);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ks_valid === 1'b1) return;
      end
      chk({name, "_timeout"}, 0, 1);
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (done === 1'b1) return;
      end
      chk({name, "_timeout"}, 0, 1);
   endtask

   task automatic go(input logic [15:0] nb);
      step(); start = 1'b1; num_blocks = nb;
      step(); start = 1'b0;
   endtask

   task automatic load(input logic [BS-1:0] v);
      step(); iv_load = 1'b1; iv_in = v;
      step(); iv_load = 1'b0;
   endtask

   logic [BS-1:0] wrap_iv;
   time           t_issue;
   bit            hold_pat [6] = '{1, 0, 0, 1, 1, 1};

   initial begin
      rst_n = 1'b0; iv_load = 1'b0; iv_in = '0; start = 1'b0; num_blocks = '0; hold = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // Basic run from counter 5
      load(128'h5);
      go(16'd3);
      wait_issue("basic_issue");
      t_issue = $time;
      chk("basic_ctr0", ctr_block, 128'h5);
      @(negedge clk); chk("basic_iv1", issue_valid, 1'b1); chk("basic_ctr1", ctr_block, 128'h6);
      @(negedge clk); chk("basic_iv2", issue_valid, 1'b1); chk("basic_ctr2", ctr_block, 128'h7);
      @(negedge clk); chk("basic_iv3", issue_valid, 1'b0);
      wait_ks("basic_ks");
      chk("basic_latency", ($time - t_issue) / 10, LAT);
      wait_done("basic_done");
      chk("basic_done_last", ks_last, 1'b1);
      chk("basic_done_delay", ($time - t_issue) / 10, LAT + 2);
      @(negedge clk); chk("basic_busy_after", busy, 1'b0);

      // Low-word wrap keeps the nonce intact
      wrap_iv = {{12{8'hA5}}, 32'hFFFF_FFFF};
      load(wrap_iv);
      go(16'd2);
      wait_issue("wrap_issue");
      chk("wrap_ctr0", ctr_block, wrap_iv);
      @(negedge clk); chk("wrap_ctr1", ctr_block, {{12{8'hA5}}, 32'h0});
      wait_done("wrap_done");

      // Hold bubbles after the first issue
      go(16'd4);
      wait_issue("hold_issue");
      for (int i = 1; i < 6; i++) begin
         step(); hold = (i <= 2);
         @(negedge clk); chk("hold_pattern", issue_valid, hold_pat[i]);
      end
      step(); hold = 1'b0;
      wait_done("hold_done");

      // Zero-length run
      step(); start = 1'b1; num_blocks = 16'd0;
      @(negedge clk); chk("zero_done_early", done, 1'b0);
      step(); start = 1'b0;
      @(negedge clk); chk("zero_done", done, 1'b1); chk("zero_busy", busy, 1'b0);

      // Start/iv_load while busy ignored; counter continues into next run
      load(128'h10);
      go(16'd2);
      wait_issue("cont_issue");
      chk("cont_ctr0", ctr_block, 128'h10);
      step(); start = 1'b1; iv_load = 1'b1; iv_in = 128'hDEAD; num_blocks = 16'd9;
      @(negedge clk); chk("cont_ctr1", ctr_block, 128'h11);
      step(); start = 1'b0; iv_load = 1'b0;
      wait_done("cont_done1");
      go(16'd2);
      wait_issue("cont_issue2");
      chk("cont_ctr2", ctr_block, 128'h12);
      @(negedge clk); chk("cont_ctr3", ctr_block, 128'h13);
      wait_done("cont_done2");

      // Load and start together: load is dropped
      step(); iv_load = 1'b1; iv_in = 128'h777; start = 1'b1; num_blocks = 16'd1;
      step(); iv_load = 1'b0; start = 1'b0;
      @(negedge clk); chk("ldstart_ctr", ctr_block, 128'h14);
      wait_done("ldstart_done");

      // Reset in the middle of a 5-block run
      go(16'd5);
      wait_issue("rst_issue");
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("rst_ctr", ctr_block, '0);
      chk("rst_outs", {issue_valid, ks_valid, ks_last, busy, done}, 5'b0);
      step(); step();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("rst_no_ks", {ks_valid, done}, 2'b0);
      end
      chk("rst_ctr_after", ctr_block, '0);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         step();
         iv_load    = ($urandom % 8) == 0;
         iv_in      = {$urandom, $urandom, $urandom,
                       (($urandom % 4) == 0) ? 32'hFFFF_FFFE : 32'($urandom)};
         start      = ($urandom % 6) == 0;
         num_blocks = 16'($urandom % 6);
         hold       = ($urandom % 3) == 0;
      end
      step();
      iv_load = 1'b0; start = 1'b0; hold = 1'b0;
      repeat (60) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/aes_ctr_feeder.md
AES_CTR_FEEDER -- requirements
Module: aes_ctr_feeder

Interface
REQ-001 SHALL have parameter block_size, default 128, meaning the width of the counter block and of the pipeline data path.
REQ-002 SHALL have parameter LATENCY, default 7, meaning the number of clock edges from the pipeline input to the pipeline output.
REQ-003 SHALL have parameter CTR_WIDTH, default 32, meaning the number of low-order counter bits that increment.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port iv_load, input, 1 bit: loads iv_in into the counter register.
REQ-007 SHALL have port iv_in, input, block_size bits: initial counter block (nonce plus counter).
REQ-008 SHALL have port start, input, 1 bit: begins a run of num_blocks blocks.
REQ-009 SHALL have port num_blocks, input, 16 bits: block count, sampled on start.
REQ-010 SHALL have port hold, input, 1 bit: suspends block issue while high.
REQ-011 SHALL have port ctr_block, output, block_size bits: counter block driven to the 7-stage round pipeline input_text.
REQ-012 SHALL have port issue_valid, output, 1 bit: ctr_block is a real block this cycle.
REQ-013 SHALL have port ks_valid, output, 1 bit: the pipeline output_text is keystream for an issued block this cycle.
REQ-014 SHALL have port ks_last, output, 1 bit: qualifies ks_valid for the final block of the run.
REQ-015 SHALL have port busy, output, 1 bit: the FSM is not IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE and DRAIN, with busy = (state != IDLE).
REQ-018 Transitions from IDLE SHALL be as follows.
- start with num_blocks > 0: go to ISSUE and latch remaining = num_blocks.
- start with num_blocks == 0: stay in IDLE and pulse done on the following cycle.
REQ-019 Transitions from ISSUE SHALL be as follows.
- Each cycle with hold == 0: issue_valid = 1; at the edge, counter increments and remaining decrements.
- When the final block issues (remaining == 1 and hold == 0): go to DRAIN.
REQ-020 Transition from DRAIN SHALL be: when ks_valid && ks_last, go to IDLE; done pulses in the same cycle as that ks_valid.
REQ-021 In IDLE and DRAIN, and in ISSUE while hold == 1, issue_valid SHALL be 0.
REQ-022 ctr_block SHALL equal the counter register at all times (registered, no combinational path from inputs).
REQ-023 Counter increment SHALL be as follows.
- Bits [CTR_WIDTH-1:0] increment modulo 2^CTR_WIDTH (all-ones wraps to zero).
- Bits [block_size-1:CTR_WIDTH] are never modified by the increment.
REQ-024 iv_load SHALL take effect only in IDLE; it is ignored while busy.
REQ-025 iv_load and start asserted in the same IDLE cycle: the load SHALL be ignored and the run uses the existing counter.
REQ-026 start while busy SHALL be ignored.
REQ-027 The counter SHALL persist after a run, so the next start continues from the next unused counter value.
REQ-028 A LATENCY-deep valid shift register SHALL be loaded with issue_valid.
- ks_valid is its last tap, so issue_valid at cycle t gives ks_valid at cycle t+LATENCY.
- A parallel last-flag shift register, loaded with (issue_valid && remaining == 1), produces ks_last.
REQ-029 hold SHALL introduce bubbles (ks_valid == 0 gaps) that appear exactly LATENCY cycles later; block order SHALL be preserved.
REQ-030 hold asserted in IDLE or DRAIN SHALL have no effect.

Reset
REQ-031 On rst_n low, asynchronously and immediately:
- state = IDLE;
- counter = 0, so ctr_block = 0;
- remaining = 0;
- both shift registers are cleared;
- issue_valid, ks_valid, ks_last, busy and done are all 0.
REQ-032 Reset asserted mid-run SHALL abandon all in-flight blocks; no ks_valid or done may appear after rst_n deasserts until a new start.

Verification
REQ-033 Basic run: iv_load iv_in=0x...0000_0005, then start num_blocks=3 ->
- issue_valid high for 3 cycles with ctr_block ...05, ...06, ...07;
- ks_valid at the issue cycle +7, for 3 consecutive cycles;
- ks_last and done on the third;
- busy deasserts the cycle after.
REQ-034 Wrap: iv_in low 32 bits = 0xFFFF_FFFF, upper 96 bits = 0xA5..A5, num_blocks=2 -> ctr_block low word 0xFFFF_FFFF then 0x0000_0000, with the upper 96 bits unchanged.
REQ-035 Hold: num_blocks=4 with hold high for 2 cycles after the first issue ->
- issue_valid pattern 1,0,0,1,1,1;
- ks_valid shows the identical pattern 7 cycles later;
- done on the 4th ks_valid.
REQ-036 Zero and illegal starts:
- start with num_blocks=0 -> no issue_valid, and done pulses one cycle later.
- start and iv_load while busy -> ignored, and the counter sequence is unaffected.
REQ-037 Reset mid-run: assert rst_n low during cycle 2 of a 5-block run ->
- all outputs 0 immediately;
- no ks_valid for 10 cycles after release;
- ctr_block = 0.
REQ-038 Continuation: two back-to-back runs of 2 blocks from iv=...10 -> the second run issues ...12 and ...13.
